// File: rtl/cic_cfg_ctrl.sv
// cic_cfg_ctrl: run-time dec_factor/bypass sequencer for the CIC decimator (drain, flush, settle).
// Optional define CIC_CFG_DROP_CNT_EN adds a dropped-sample counter (drop_clr/drop_cnt).
module cic_cfg_ctrl #(
    parameter int unsigned DEC_WIDTH      = 4,
    parameter int unsigned DRAIN_CYCLES   = 4,
    parameter int unsigned FLUSH_CYCLES   = 2,
    parameter int unsigned SETTLE_SAMPLES = 2,
    parameter int unsigned RST_DEC_FACTOR = 1
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef CIC_CFG_DROP_CNT_EN
    input  logic               drop_clr,
    output logic [15:0]        drop_cnt,
`endif
    input  logic               cfg_req,
    input  logic [DEC_WIDTH:0] cfg_dec_factor,
    input  logic               cfg_bypass,
    output logic               cfg_ack,
    output logic               cfg_err,
    output logic               busy,
    input  logic               valid_in,
    output logic               valid_gated,
    input  logic               cic_valid_out,
    output logic               valid_out,
    output logic [DEC_WIDTH:0] cic_dec_factor,
    output logic               cic_bypass,
    output logic               flush_n
);

    localparam int unsigned FW      = DEC_WIDTH + 1;
    localparam int unsigned MAX_DF  = (DRAIN_CYCLES > FLUSH_CYCLES) ? DRAIN_CYCLES : FLUSH_CYCLES;
    localparam int unsigned MAX_CNT = (MAX_DF > SETTLE_SAMPLES) ? MAX_DF : SETTLE_SAMPLES;
    localparam int unsigned CW      = (MAX_CNT < 1) ? 1 : $clog2(MAX_CNT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        FLUSH  = 2'd2,
        SETTLE = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          gate_en;
    logic          out_en;
    logic          started;
    logic          req_legal;
    logic          req_same;

    // Legal factors are the powers of two representable in the port: exactly one bit set.
    assign req_legal = (cfg_dec_factor != '0) &&
                       ((cfg_dec_factor & (cfg_dec_factor - FW'(1))) == '0);
    assign req_same  = (cfg_dec_factor == cic_dec_factor) && (cfg_bypass == cic_bypass);

    assign valid_gated = valid_in & gate_en;
    assign valid_out   = cic_valid_out & out_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            gate_en        <= 1'b0;
            out_en         <= 1'b0;
            started        <= 1'b0;
            busy           <= 1'b0;
            cfg_ack        <= 1'b0;
            cfg_err        <= 1'b0;
            flush_n        <= 1'b0;
            cic_bypass     <= 1'b0;
            cic_dec_factor <= FW'(RST_DEC_FACTOR);
        end else begin
            cfg_ack <= 1'b0;
            cfg_err <= 1'b0;
            if (!started) begin
                // First clock after reset release: release the CIC and open both gates.
                started <= 1'b1;
                flush_n <= 1'b1;
                gate_en <= 1'b1;
                out_en  <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        // A request still high during the ack cycle is not re-sampled.
                        if (cfg_req && !cfg_ack) begin
                            if (!req_legal) begin
                                cfg_ack <= 1'b1;
                                cfg_err <= 1'b1;
                            end else if (req_same) begin
                                cfg_ack <= 1'b1;
                            end else begin
                                gate_en <= 1'b0;
                                out_en  <= 1'b0;
                                busy    <= 1'b1;
                                cnt     <= CW'(DRAIN_CYCLES - 1);
                                state   <= DRAIN;
                            end
                        end
                    end
                    DRAIN: begin
                        if (cnt == '0) begin
                            flush_n        <= 1'b0;
                            cic_dec_factor <= cfg_dec_factor;
                            cic_bypass     <= cfg_bypass;
                            cnt            <= CW'(FLUSH_CYCLES - 1);
                            state          <= FLUSH;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                    FLUSH: begin
                        if (cnt == '0) begin
                            flush_n <= 1'b1;
                            gate_en <= 1'b1;
                            cnt     <= CW'(SETTLE_SAMPLES);
                            if (cic_bypass || (SETTLE_SAMPLES == 0)) begin
                                out_en  <= 1'b1;
                                busy    <= 1'b0;
                                cfg_ack <= 1'b1;
                                state   <= IDLE;
                            end else begin
                                state <= SETTLE;
                            end
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                    SETTLE: begin
                        // Discard CIC strobes until the comb delays hold post-flush data.
                        if (cic_valid_out) begin
                            if (cnt <= CW'(1)) begin
                                cnt     <= '0;
                                out_en  <= 1'b1;
                                busy    <= 1'b0;
                                cfg_ack <= 1'b1;
                                state   <= IDLE;
                            end else begin
                                cnt <= cnt - CW'(1);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef CIC_CFG_DROP_CNT_EN
    // Saturating count of upstream samples dropped by the input gate; clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= 16'd0;
        end else if (drop_clr) begin
            drop_cnt <= 16'd0;
        end else if (valid_in && !gate_en && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule
